// File: rtl/heartbeat_failover.sv
// Redundant-CPU I/O ownership arbiter: per-channel heartbeat watchdogs feed a
// small FSM that picks the active CPU, fails over automatically and honours forced switches.
module heartbeat_failover #(
   parameter int N_CPU   = 2,
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 50000,
   parameter int HOLDOFF = 1000,
   localparam int SEL_W  = (N_CPU > 1) ? $clog2(N_CPU) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_CPU-1:0] hb,
   input  logic             force_req,
   input  logic [SEL_W-1:0] force_sel,
   output logic [SEL_W-1:0] active_sel,
   output logic [N_CPU-1:0] active_onehot,
   output logic [N_CPU-1:0] healthy,
   output logic             all_fail,
   output logic             switch_pulse,
   output logic             force_err,
   output logic [1:0]       state
);

   localparam int HOLD_W = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

   typedef enum logic [1:0] {
      ST_INIT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2,
      ST_FAIL = 2'd3
   } state_t;

   state_t              state_reg;
   logic [SEL_W-1:0]    active_sel_reg;
   logic [N_CPU-1:0]    active_onehot_reg;
   logic                all_fail_reg;
   logic                switch_pulse_reg;
   logic                force_err_reg;
   logic [HOLD_W-1:0]   hold_cnt_reg;
   logic [N_CPU-1:0]    healthy_vec;

   // Per-channel synchroniser, edge detector and saturating watchdog.
   genvar gi;
   generate
      for (gi = 0; gi < N_CPU; gi++) begin : g_ch
         logic             hb_meta_reg;
         logic             hb_sync_reg;
         logic             hb_prev_reg;
         logic [CNT_W-1:0] wd_cnt_reg;
         logic             ok_reg;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               hb_meta_reg <= 1'b0;
               hb_sync_reg <= 1'b0;
               hb_prev_reg <= 1'b0;
               wd_cnt_reg  <= CNT_W'(TIMEOUT);
               ok_reg      <= 1'b0;
            end else begin
               hb_meta_reg <= hb[gi];
               hb_sync_reg <= hb_meta_reg;
               hb_prev_reg <= hb_sync_reg;
               if (hb_sync_reg ^ hb_prev_reg)
                  wd_cnt_reg <= '0;
               else if (wd_cnt_reg < CNT_W'(TIMEOUT))
                  wd_cnt_reg <= wd_cnt_reg + 1'b1;
               ok_reg <= (wd_cnt_reg < CNT_W'(TIMEOUT));
            end
         end

         assign healthy_vec[gi] = ok_reg;
      end
   endgenerate

   function automatic int wrap_idx(input int v);
      return (v >= N_CPU) ? v - N_CPU : v;
   endfunction

   function automatic logic [N_CPU-1:0] onehot_of(input logic [SEL_W-1:0] sel);
      logic [N_CPU-1:0] v;
      v = '0;
      for (int i = 0; i < N_CPU; i++)
         if (int'(sel) == i) v[i] = 1'b1;
      return v;
   endfunction

   logic [SEL_W-1:0] cand_init, cand_run, cand_fail, target;
   logic             found_init, found_run, found_fail;
   logic             active_ok, force_ok, force_valid, go;

   // Lower search offsets are visited last so they win the priority.
   always_comb begin
      cand_init  = '0;
      found_init = 1'b0;
      cand_run   = '0;
      found_run  = 1'b0;
      active_ok  = 1'b0;
      force_ok   = 1'b0;
      for (int j = N_CPU - 1; j >= 0; j--) begin
         if (healthy_vec[j]) begin
            cand_init  = SEL_W'(j);
            found_init = 1'b1;
         end
      end
      for (int j = N_CPU - 1; j >= 1; j--) begin
         for (int i = 0; i < N_CPU; i++) begin
            if (healthy_vec[i] && (i == wrap_idx(int'(active_sel_reg) + j))) begin
               cand_run  = SEL_W'(i);
               found_run = 1'b1;
            end
         end
      end
      for (int i = 0; i < N_CPU; i++) begin
         if (int'(active_sel_reg) == i) active_ok = healthy_vec[i];
         if (int'(force_sel) == i)      force_ok  = healthy_vec[i];
      end
      // Leaving FAIL, the current index is tried after every other one.
      found_fail  = found_run | active_ok;
      cand_fail   = found_run ? cand_run : active_sel_reg;
      force_valid = force_req && force_ok && (force_sel != active_sel_reg);
   end

   always_comb begin
      go     = 1'b0;
      target = '0;
      case (state_reg)
         ST_INIT: begin
            go     = found_init;
            target = cand_init;
         end
         ST_RUN: begin
            if (force_valid) begin
               go     = 1'b1;
               target = force_sel;
            end else if (!active_ok) begin
               go     = found_run;
               target = cand_run;
            end
         end
         ST_FAIL: begin
            go     = found_fail;
            target = cand_fail;
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg         <= ST_INIT;
         active_sel_reg    <= '0;
         active_onehot_reg <= '0;
         all_fail_reg      <= 1'b0;
         switch_pulse_reg  <= 1'b0;
         force_err_reg     <= 1'b0;
         hold_cnt_reg      <= '0;
      end else begin
         switch_pulse_reg <= 1'b0;
         force_err_reg    <= 1'b0;
         case (state_reg)
            ST_RUN: begin
               if (!force_valid) begin
                  force_err_reg <= force_req && (force_sel != active_sel_reg);
                  if (!active_ok && !found_run) begin
                     state_reg         <= ST_FAIL;
                     active_onehot_reg <= '0;
                     all_fail_reg      <= 1'b1;
                  end
               end
            end
            ST_HOLD: begin
               force_err_reg <= force_req;
               if (hold_cnt_reg != '0) hold_cnt_reg <= hold_cnt_reg - 1'b1;
               if (hold_cnt_reg <= HOLD_W'(1)) state_reg <= ST_RUN;
            end
            default: begin
            end
         endcase
         if (go) begin
            state_reg         <= ST_HOLD;
            active_sel_reg    <= target;
            active_onehot_reg <= onehot_of(target);
            switch_pulse_reg  <= 1'b1;
            all_fail_reg      <= 1'b0;
            hold_cnt_reg      <= HOLD_W'(HOLDOFF);
         end
      end
   end

   assign active_sel    = active_sel_reg;
   assign active_onehot = active_onehot_reg;
   assign healthy       = healthy_vec;
   assign all_fail      = all_fail_reg;
   assign switch_pulse  = switch_pulse_reg;
   assign force_err     = force_err_reg;
   assign state         = state_reg;

endmodule

// File: tb/tb_heartbeat_failover.sv
// Bench for heartbeat_failover (N_CPU=3, TIMEOUT=16, HOLDOFF=8): scripted and random
// heartbeat/force stimulus compared each cycle against a timestamp-based reference model.
module tb_heartbeat_failover;

   localparam int N  = 3;
   localparam int T  = 16;
   localparam int H  = 8;
   localparam int SW = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic [N-1:0]  hb = '0;
   logic          force_req = 1'b0;
   logic [SW-1:0] force_sel = '0;
   logic [SW-1:0] active_sel;
   logic [N-1:0]  active_onehot;
   logic [N-1:0]  healthy;
   logic          all_fail;
   logic          switch_pulse;
   logic          force_err;
   logic [1:0]    state;

   int tests_run = 0;
   int tests_failed = 0;

   heartbeat_failover #(.N_CPU(N), .CNT_W(8), .TIMEOUT(T), .HOLDOFF(H)) dut (
      .clk(clk), .rst_n(rst_n), .hb(hb), .force_req(force_req), .force_sel(force_sel),
      .active_sel(active_sel), .active_onehot(active_onehot), .healthy(healthy),
      .all_fail(all_fail), .switch_pulse(switch_pulse), .force_err(force_err), .state(state)
   );

   always #5 clk = ~clk;

   // Reference model: heartbeat history as pin-toggle timestamps, ownership as plain variables.
   int cyc;
   int hist[N][8];
   int m_state, m_sel, m_hold;
   bit m_pulse, m_err;

   function automatic bit is_set(input logic [N-1:0] v, input int i);
      return ((int'(v) >> i) & 1) != 0;
   endfunction

   // A pin edge is seen by the health flag 4 cycles later and lasts TIMEOUT+3 cycles.
   function automatic logic [N-1:0] model_healthy(input int q);
      logic [N-1:0] h = '0;
      logic [N-1:0] one = 1;
      for (int c = 0; c < N; c++) begin
         bit done = 0;
         for (int m = 0; m < 8; m++) begin
            if (!done && hist[c][m] <= q - 4) begin
               done = 1;
               if (q - hist[c][m] <= T + 3) h = h | (one << c);
            end
         end
      end
      return h;
   endfunction

   task automatic model_switch(input int to);
      m_sel = to; m_pulse = 1; m_state = 2; m_hold = H;
   endtask

   task automatic model_fsm(input logic [N-1:0] h);
      int fs;
      bit found;
      int c;
      m_pulse = 0; m_err = 0;
      fs = int'(force_sel);
      found = 0; c = 0;
      case (m_state)
         0: begin
            for (int j = 0; j < N; j++)
               if (!found && is_set(h, j)) begin found = 1; c = j; end
            if (found) model_switch(c);
         end
         1: begin
            if (force_req && fs < N && is_set(h, fs) && fs != m_sel) model_switch(fs);
            else begin
               if (force_req && fs != m_sel) m_err = 1;
               if (!is_set(h, m_sel)) begin
                  for (int j = 1; j < N; j++)
                     if (!found && is_set(h, (m_sel + j) % N)) begin found = 1; c = (m_sel + j) % N; end
                  if (found) model_switch(c);
                  else m_state = 3;
               end
            end
         end
         2: begin
            m_err = force_req;
            m_hold = m_hold - 1;
            if (m_hold == 0) m_state = 1;
         end
         default: begin
            for (int j = 1; j <= N; j++)
               if (!found && is_set(h, (m_sel + j) % N)) begin found = 1; c = (m_sel + j) % N; end
            if (found) model_switch(c);
         end
      endcase
   endtask

   function automatic logic [12:0] exp_vec();
      logic [N-1:0] oh = '0;
      logic [N-1:0] one = 1;
      if (m_state == 1 || m_state == 2) oh = one << m_sel;
      return {2'(m_state), 2'(m_sel), oh, model_healthy(cyc), (m_state == 3), m_pulse, m_err};
   endfunction

   function automatic logic [12:0] obs_vec();
      return {state, active_sel, active_onehot, healthy, all_fail, switch_pulse, force_err};
   endfunction

   task automatic toggle(input int c);
      logic [N-1:0] one = 1;
      hb = hb ^ (one << c);
      for (int m = 7; m > 0; m--) hist[c][m] = hist[c][m-1];
      hist[c][0] = cyc;
   endtask

   // Period-6 heartbeat on every channel in mask.
   task automatic drive_hb(input logic [N-1:0] mask);
      if (cyc % 3 == 0)
         for (int c = 0; c < N; c++)
            if (is_set(mask, c)) toggle(c);
   endtask

   task automatic tick();
      @(posedge clk);
      model_fsm(model_healthy(cyc));
      cyc++;
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; hb = '0; force_req = 1'b0; force_sel = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      cyc = 0; m_state = 0; m_sel = 0; m_hold = 0; m_pulse = 0; m_err = 0;
      for (int c = 0; c < N; c++)
         for (int m = 0; m < 8; m++) hist[c][m] = -100000;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #1;
      tests_run++;
      if (obs_vec() !== 13'b0) begin
         tests_failed++;
         $display("FAIL reset_async got=%b want=%b", obs_vec(), 13'b0);
      end
      do_reset();
      for (int i = 0; i < 10; i++) begin
         tick();
         tests_run++;
         if (obs_vec() !== exp_vec()) begin
            tests_failed++;
            $display("FAIL reset_idle cyc=%0d got=%b want=%b", cyc, obs_vec(), exp_vec());
         end
      end
      tests_run++;
      if (state !== 2'd0 || healthy !== 3'b000) begin
         tests_failed++;
         $display("FAIL reset_init got state=%0d healthy=%b want state=0 healthy=000", state, healthy);
      end
      $display("[TB] test_reset done at cyc %0d", cyc);
   endtask

   task automatic test_single_channel();
      int first_h = -1, pulses = 0, hold_cycles = 0;
      do_reset();
      for (int i = 0; i < 80; i++) begin
         drive_hb(3'b010);
         tick();
         tests_run++;
         if (obs_vec() !== exp_vec()) begin
            tests_failed++;
            $display("FAIL single cyc=%0d got=%b want=%b", cyc, obs_vec(), exp_vec());
         end
         if (first_h < 0 && healthy == 3'b010) first_h = cyc;
         if (switch_pulse) pulses++;
         if (state == 2'd2) hold_cycles++;
      end
      tests_run++;
      if (first_h < 0 || first_h > 4 || pulses != 1 || hold_cycles != H || active_sel !== 2'd1 || state !== 2'd1) begin
         tests_failed++;
         $display("FAIL single_summary got first_h=%0d pulses=%0d hold=%0d sel=%0d state=%0d want <=4,1,%0d,1,1",
                  first_h, pulses, hold_cycles, active_sel, state, H);
      end
      $display("[TB] test_single_channel healthy at cyc %0d, %0d hold cycles", first_h, hold_cycles);
   endtask

   task automatic test_failover();
      int fall = -1;
      do_reset();
      for (int i = 0; i < 100; i++) begin
         drive_hb(i < 40 ? 3'b111 : 3'b110);
         tick();
         tests_run++;
         if (obs_vec() !== exp_vec()) begin
            tests_failed++;
            $display("FAIL failover cyc=%0d got=%b want=%b", cyc, obs_vec(), exp_vec());
         end
         if (i == 39) begin
            tests_run++;
            if (active_sel !== 2'd0 || state !== 2'd1) begin
               tests_failed++;
               $display("FAIL failover_pre got sel=%0d state=%0d want sel=0 state=1", active_sel, state);
            end
         end
         if (fall >= 0 && cyc == fall + 1) begin
            tests_run++;
            if (active_sel !== 2'd1 || switch_pulse !== 1'b1) begin
               tests_failed++;
               $display("FAIL failover_switch got sel=%0d pulse=%0d want sel=1 pulse=1", active_sel, switch_pulse);
            end
         end
         if (i >= 40 && fall < 0 && healthy[0] == 1'b0) fall = cyc;
      end
      tests_run++;
      if (fall < 0) begin
         tests_failed++;
         $display("FAIL failover_timeout got no health drop want healthy[0]=0");
      end
      $display("[TB] test_failover healthy[0] dropped at cyc %0d", fall);
   endtask

   task automatic test_all_fail();
      bit saw_fail = 0;
      do_reset();
      for (int i = 0; i < 120; i++) begin
         drive_hb(i < 40 ? 3'b111 : (i < 80 ? 3'b000 : 3'b001));
         tick();
         tests_run++;
         if (obs_vec() !== exp_vec()) begin
            tests_failed++;
            $display("FAIL all_fail cyc=%0d got=%b want=%b", cyc, obs_vec(), exp_vec());
         end
         if (i == 79) begin
            saw_fail = (state == 2'd3);
            tests_run++;
            if (state !== 2'd3 || all_fail !== 1'b1 || active_onehot !== 3'b000) begin
               tests_failed++;
               $display("FAIL all_fail_state got state=%0d all_fail=%0d onehot=%b want 3,1,000",
                        state, all_fail, active_onehot);
            end
         end
      end
      tests_run++;
      if (active_sel !== 2'd0 || state !== 2'd1 || all_fail !== 1'b0) begin
         tests_failed++;
         $display("FAIL all_fail_recover got sel=%0d state=%0d all_fail=%0d want 0,1,0", active_sel, state, all_fail);
      end
      $display("[TB] test_all_fail fail_seen=%0d recovered to %0d", saw_fail, active_sel);
   endtask

   task automatic test_force();
      logic [5:0] want;
      for (int i = 0; i < 90; i++) begin
         if (i == 0) do_reset();
         drive_hb(3'b111);
         force_req = (i == 40 || i == 45 || i == 47 || i == 70);
         force_sel = (i == 40) ? 2'd3 : ((i == 47) ? 2'd1 : 2'd2);
         tick();
         force_req = 1'b0;
         tests_run++;
         if (obs_vec() !== exp_vec()) begin
            tests_failed++;
            $display("FAIL force cyc=%0d got=%b want=%b", cyc, obs_vec(), exp_vec());
         end
         if (i == 40 || i == 45 || i == 47 || i == 70) begin
            // {force_err, switch_pulse, active_sel, state}
            case (i)
               40:      want = {1'b1, 1'b0, 2'd0, 2'd1};
               45:      want = {1'b0, 1'b1, 2'd2, 2'd2};
               47:      want = {1'b1, 1'b0, 2'd2, 2'd2};
               default: want = {1'b0, 1'b0, 2'd2, 2'd1};
            endcase
            tests_run++;
            if ({force_err, switch_pulse, active_sel, state} !== want) begin
               tests_failed++;
               $display("FAIL force_event i=%0d got=%b want=%b", i, {force_err, switch_pulse, active_sel, state}, want);
            end
            $display("[TB] force at cyc %0d: err=%0d active=%0d state=%0d", cyc, force_err, active_sel, state);
         end
      end
   endtask

   task automatic test_force_race();
      bit fired = 0;
      do_reset();
      for (int i = 0; i < 100; i++) begin
         bit now = 0;
         drive_hb(i < 40 ? 3'b111 : 3'b110);
         if (!fired && i >= 40 && m_state == 1 && !is_set(model_healthy(cyc), 0)) begin
            force_req = 1'b1; force_sel = 2'd2; fired = 1; now = 1;
         end
         tick();
         force_req = 1'b0;
         tests_run++;
         if (obs_vec() !== exp_vec()) begin
            tests_failed++;
            $display("FAIL race cyc=%0d got=%b want=%b", cyc, obs_vec(), exp_vec());
         end
         if (now) begin
            tests_run++;
            if (active_sel !== 2'd2 || switch_pulse !== 1'b1 || state !== 2'd2) begin
               tests_failed++;
               $display("FAIL race_winner got sel=%0d pulse=%0d state=%0d want 2,1,2", active_sel, switch_pulse, state);
            end
            $display("[TB] race force at cyc %0d -> active %0d", cyc, active_sel);
         end
      end
      tests_run++;
      if (!fired) begin
         tests_failed++;
         $display("FAIL race_timeout got no failure window want one");
      end
   endtask

   task automatic test_random();
      bit alive[N];
      do_reset();
      for (int c = 0; c < N; c++) alive[c] = 1;
      for (int i = 0; i < 800; i++) begin
         for (int c = 0; c < N; c++) begin
            if ($urandom_range(63) == 0) alive[c] = !alive[c];
            if (alive[c] && $urandom_range(3) == 0) toggle(c);
         end
         force_req = ($urandom_range(15) == 0);
         force_sel = SW'($urandom_range(3));
         tick();
         force_req = 1'b0;
         tests_run++;
         if (obs_vec() !== exp_vec()) begin
            tests_failed++;
            $display("FAIL random cyc=%0d got=%b want=%b", cyc, obs_vec(), exp_vec());
         end
      end
      $display("[TB] test_random ended at cyc %0d state=%0d active=%0d", cyc, state, active_sel);
   endtask

   task automatic test_reset_mid_hold();
      int pulses = 0;
      do_reset();
      for (int i = 0; i < 8; i++) begin
         drive_hb(3'b111);
         tick();
      end
      tests_run++;
      if (state !== 2'd2) begin
         tests_failed++;
         $display("FAIL mid_hold_pre got state=%0d want 2", state);
      end
      #2;
      rst_n = 1'b0;
      #1;
      tests_run++;
      if (obs_vec() !== 13'b0) begin
         tests_failed++;
         $display("FAIL mid_hold_async got=%b want=%b", obs_vec(), 13'b0);
      end
      do_reset();
      for (int i = 0; i < 30; i++) begin
         drive_hb(3'b111);
         tick();
         tests_run++;
         if (obs_vec() !== exp_vec()) begin
            tests_failed++;
            $display("FAIL mid_hold_after cyc=%0d got=%b want=%b", cyc, obs_vec(), exp_vec());
         end
         if (switch_pulse) pulses++;
      end
      tests_run++;
      if (pulses != 1) begin
         tests_failed++;
         $display("FAIL mid_hold_pulses got=%0d want=1", pulses);
      end
      $display("[TB] test_reset_mid_hold pulses after release=%0d", pulses);
   endtask

   initial begin
      #2;
      test_reset();
      test_single_channel();
      test_failover();
      test_all_fail();
      test_force();
      test_force_race();
      test_random();
      test_reset_mid_hold();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "bench timeout");
   end

endmodule
